// File: rtl/neo_sdcmd_pkg.sv
// Shared constants for the NEO sound-command mailbox: data width, default
// synchronizer depth and the value both latches take in reset.
package neo_sdcmd_pkg;

    localparam int DATA_W          = 8;
    localparam int SYNC_STAGES_DEF = 2;

    typedef logic [DATA_W-1:0] data_t;

    localparam data_t LATCH_RST = 8'h00;

endpackage

// File: rtl/neo_strobe_sync.sv
// Synchronizes one active-low bus strobe into CLK_24M and emits a one-cycle
// commit pulse when the synchronized strobe is released (low-to-high).
module neo_strobe_sync
    import neo_sdcmd_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES_DEF
) (
    input  logic CLK_24M,
    input  logic nRESET,
    input  logic strobe_n,
    output logic sync_low,
    output logic commit
);

    logic [STAGES-1:0] sync_p;
    logic              prev_p;

    // Reset loads the idle (high) level so a strobe held low across reset
    // release looks like a fresh falling edge, never a release.
    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            sync_p <= '1;
            prev_p <= 1'b1;
        end else begin
            sync_p <= {sync_p[STAGES-2:0], strobe_n};
            prev_p <= sync_p[STAGES-1];
        end
    end

    assign sync_low = ~sync_p[STAGES-1];
    assign commit   = sync_p[STAGES-1] & ~prev_p;

endmodule

// File: rtl/neo_sdcmd.sv
// 68K <-> Z80 sound-command mailbox: a command latch written by the 68K and
// read/cleared by the Z80, and a reply latch in the opposite direction.
module neo_sdcmd
    import neo_sdcmd_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              CLK_24M,
    input  logic              nRESET,
    input  logic              nSDW,
    input  logic              nSDR68K,
    input  logic [DATA_W-1:0] M68K_DIN,
    output logic [DATA_W-1:0] M68K_DOUT,
    output logic              M68K_OE,
    input  logic              nSDZ80R,
    input  logic              nSDZ80CLR,
    input  logic              nSDZ80W,
    input  logic [DATA_W-1:0] SDD_IN,
    output logic [DATA_W-1:0] SDD_OUT,
    output logic              SDD_OE,
    output logic              CMD_PEND,
    output logic              RPLY_PEND,
    output logic              CMD_OVR,
    output logic              RPLY_OVR
);

    logic  sdw_low, sdw_commit;
    logic  r68_low, r68_commit;
    logic  cmd_rd_low, cmd_rd_commit;
    logic  clr_low, clr_commit;
    logic  z80w_low, z80w_commit;
    data_t hold_cmd, hold_rply;
    data_t cmd_latch, rply_latch;
    logic  cmd_pend, cmd_ovr, rply_pend, rply_ovr;

    neo_strobe_sync #(.STAGES(SYNC_STAGES)) u_sdw (
        .CLK_24M(CLK_24M), .nRESET(nRESET), .strobe_n(nSDW),
        .sync_low(sdw_low), .commit(sdw_commit));
    neo_strobe_sync #(.STAGES(SYNC_STAGES)) u_sdr68k (
        .CLK_24M(CLK_24M), .nRESET(nRESET), .strobe_n(nSDR68K),
        .sync_low(r68_low), .commit(r68_commit));
    neo_strobe_sync #(.STAGES(SYNC_STAGES)) u_sdz80r (
        .CLK_24M(CLK_24M), .nRESET(nRESET), .strobe_n(nSDZ80R),
        .sync_low(cmd_rd_low), .commit(cmd_rd_commit));
    neo_strobe_sync #(.STAGES(SYNC_STAGES)) u_sdz80clr (
        .CLK_24M(CLK_24M), .nRESET(nRESET), .strobe_n(nSDZ80CLR),
        .sync_low(clr_low), .commit(clr_commit));
    neo_strobe_sync #(.STAGES(SYNC_STAGES)) u_sdz80w (
        .CLK_24M(CLK_24M), .nRESET(nRESET), .strobe_n(nSDZ80W),
        .sync_low(z80w_low), .commit(z80w_commit));

    // Read/clear strobes only need their commit pulse.
    logic unused_sync_low;
    assign unused_sync_low = &{1'b0, r68_low, cmd_rd_low, clr_low};

    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            hold_cmd   <= '0;
            hold_rply  <= '0;
            cmd_latch  <= LATCH_RST;
            rply_latch <= LATCH_RST;
            cmd_pend   <= 1'b0;
            cmd_ovr    <= 1'b0;
            rply_pend  <= 1'b0;
            rply_ovr   <= 1'b0;
        end else begin
            if (sdw_low)
                hold_cmd <= M68K_DIN;
            if (z80w_low)
                hold_rply <= SDD_IN;

            // A write always wins on its latch; a coincident clear still wipes overrun.
            if (sdw_commit) begin
                cmd_latch <= hold_cmd;
                cmd_pend  <= 1'b1;
                cmd_ovr   <= clr_commit ? 1'b0 : (cmd_ovr | cmd_pend);
            end else if (clr_commit) begin
                cmd_latch <= LATCH_RST;
                cmd_pend  <= 1'b0;
                cmd_ovr   <= 1'b0;
            end else if (cmd_rd_commit) begin
                cmd_pend  <= 1'b0;
            end

            if (z80w_commit) begin
                rply_latch <= hold_rply;
                rply_pend  <= 1'b1;
                rply_ovr   <= r68_commit ? 1'b0 : (rply_ovr | rply_pend);
            end else if (r68_commit) begin
                rply_pend  <= 1'b0;
                rply_ovr   <= 1'b0;
            end
        end
    end

    assign SDD_OUT   = cmd_latch;
    assign M68K_DOUT = rply_latch;
    assign CMD_PEND  = cmd_pend;
    assign CMD_OVR   = cmd_ovr;
    assign RPLY_PEND = rply_pend;
    assign RPLY_OVR  = rply_ovr;
    assign SDD_OE    = ~nSDZ80R;
    assign M68K_OE   = ~nSDR68K;

endmodule
